mips_lsu: RTL and testbench

Multi-cycle load/store unit between the single-cycle MIPS core's execute stage and the data memory port. It does the following:
- takes the effective address from the ALU, the store data (rt), and a memory op from the decoder;
- generates aligned byte lanes and the 4-bit write mask;
- runs a request/acknowledge handshake with a variable-latency memory;
- returns the sign- or zero-extended load result.

While an access is outstanding it stalls the core (PC and register-file enables). It flags AdEL, AdES and DBE conditions to `exception_unit`.

---
 rtl/mips_lsu_pkg.sv | 37 +++
 rtl/mips_lsu_lane_align.sv | 60 ++++++
 rtl/mips_lsu.sv | 128 ++++++++++++
 tb/tb_mips_lsu.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_lsu_pkg.sv
// Shared types for the MIPS load/store unit: memory op encoding (also used by
// the decoder), FSM state encoding and small op-classification helpers.
package mips_lsu_pkg;

    typedef enum logic [2:0] {
        LSU_LB  = 3'd0,
        LSU_LH  = 3'd1,
        LSU_LW  = 3'd2,
        LSU_LBU = 3'd3,
        LSU_LHU = 3'd4,
        LSU_SB  = 3'd5,
        LSU_SH  = 3'd6,
        LSU_SW  = 3'd7
    } lsu_op_t;

    typedef enum logic [1:0] {
        LSU_IDLE   = 2'd0,
        LSU_ACCESS = 2'd1,
        LSU_RESP   = 2'd2
    } lsu_state_t;

    localparam int LSU_TIMEOUT_DEFAULT = 255;

    function automatic logic is_store(input lsu_op_t op);
        return (op == LSU_SB) || (op == LSU_SH) || (op == LSU_SW);
    endfunction

    // Byte ops never fault; halves need addr[0]=0, words need addr[1:0]=0.
    function automatic logic is_misaligned(input lsu_op_t op, input logic [1:0] lo);
        case (op)
            LSU_LH, LSU_LHU, LSU_SH: return lo[0];
            LSU_LW, LSU_SW:          return |lo;
            default:                 return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mips_lsu_lane_align.sv
// Combinational byte-lane logic: store mask and data replication, plus load
// byte/half extraction with sign or zero extension.
module lsu_lane_align
    import mips_lsu_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [3:0]  wmask,
    output logic [31:0] wdata_rep,
    output logic [31:0] rdata_ext
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rword[7:0];
        case (addr_lo)
            2'd0: byte_sel = rword[7:0];
            2'd1: byte_sel = rword[15:8];
            2'd2: byte_sel = rword[23:16];
            2'd3: byte_sel = rword[31:24];
            default: byte_sel = rword[7:0];
        endcase
        half_sel = addr_lo[1] ? rword[31:16] : rword[15:0];
    end

    always_comb begin
        wmask     = 4'b0000;
        wdata_rep = 32'd0;
        rdata_ext = 32'd0;
        case (op)
            LSU_LB:  rdata_ext = {{24{byte_sel[7]}}, byte_sel};
            LSU_LBU: rdata_ext = {24'd0, byte_sel};
            LSU_LH:  rdata_ext = {{16{half_sel[15]}}, half_sel};
            LSU_LHU: rdata_ext = {16'd0, half_sel};
            LSU_LW:  rdata_ext = rword;
            LSU_SB: begin
                wdata_rep = {4{wdata[7:0]}};
                wmask     = 4'b0001 << addr_lo;
            end
            LSU_SH: begin
                wdata_rep = {2{wdata[15:0]}};
                wmask     = addr_lo[1] ? 4'b1100 : 4'b0011;
            end
            LSU_SW: begin
                wdata_rep = wdata;
                wmask     = 4'b1111;
            end
            default: begin
                wmask     = 4'b0000;
                wdata_rep = 32'd0;
                rdata_ext = 32'd0;
            end
        endcase
    end

endmodule

// File: rtl/mips_lsu.sv
// Multi-cycle load/store unit: IDLE -> ACCESS -> RESP sequencing, alignment
// exceptions, bus-error/timeout detection and core stall generation.
module mips_lsu
    import mips_lsu_pkg::*;
#(
    parameter int TIMEOUT = LSU_TIMEOUT_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_b,
    input  logic        lsu_start,
    input  logic [2:0]  lsu_op,
    input  logic [31:0] lsu_addr,
    input  logic [31:0] lsu_wdata,
    output logic [31:0] lsu_rdata,
    output logic        lsu_stall,
    output logic        lsu_done,
    output logic        lsu_adel,
    output logic        lsu_ades,
    output logic        lsu_dbe,
    output logic [29:0] mem_addr,
    output logic [31:0] mem_data_in,
    output logic [3:0]  mem_write_en,
    output logic        mem_req,
    input  logic        mem_ack,
    input  logic [31:0] mem_data_out,
    input  logic        mem_excpt,
    output logic [1:0]  dbg_state
);

    // Memory handshake: mem_req stays high with addr/data/mask stable until the
    // first cycle with mem_ack=1; mem_excpt is only looked at in that cycle.

    lsu_state_t  state;
    lsu_op_t     op_in;
    lsu_op_t     op_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] rword_q;
    logic [7:0]  cnt_q;
    logic        adel_q;
    logic        ades_q;
    logic        dbe_q;
    logic        misaligned;
    logic        in_access;
    logic        in_resp;
    logic [3:0]  lane_mask;
    logic [31:0] lane_wdata;
    logic [31:0] lane_rdata;

    assign op_in      = lsu_op_t'(lsu_op);
    assign misaligned = is_misaligned(op_in, lsu_addr[1:0]);

    always_ff @(posedge clk) begin
        if (!rst_b) begin
            state   <= LSU_IDLE;
            op_q    <= LSU_LB;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            rword_q <= 32'd0;
            cnt_q   <= 8'd0;
            adel_q  <= 1'b0;
            ades_q  <= 1'b0;
            dbe_q   <= 1'b0;
        end else begin
            case (state)
                LSU_IDLE: begin
                    if (lsu_start) begin
                        op_q    <= op_in;
                        addr_q  <= lsu_addr;
                        wdata_q <= lsu_wdata;
                        rword_q <= 32'd0;
                        cnt_q   <= 8'd0;
                        adel_q  <= misaligned && !is_store(op_in);
                        ades_q  <= misaligned && is_store(op_in);
                        dbe_q   <= 1'b0;
                        state   <= misaligned ? LSU_RESP : LSU_ACCESS;
                    end
                end
                LSU_ACCESS: begin
                    if (mem_ack) begin
                        if (mem_excpt) begin
                            dbe_q <= 1'b1;
                        end else begin
                            rword_q <= mem_data_out;
                        end
                        state <= LSU_RESP;
                    end else if (cnt_q == 8'(TIMEOUT)) begin
                        dbe_q <= 1'b1;
                        state <= LSU_RESP;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                LSU_RESP: state <= LSU_IDLE;
                default:  state <= LSU_IDLE;
            endcase
        end
    end

    lsu_lane_align u_lane (
        .op        (op_q),
        .addr_lo   (addr_q[1:0]),
        .wdata     (wdata_q),
        .rword     (rword_q),
        .wmask     (lane_mask),
        .wdata_rep (lane_wdata),
        .rdata_ext (lane_rdata)
    );

    assign in_access = (state == LSU_ACCESS);
    assign in_resp   = (state == LSU_RESP);

    // Stall drops in RESP so the core commits the instruction on that edge.
    assign lsu_stall    = ((state == LSU_IDLE) && lsu_start) || in_access;
    assign mem_req      = in_access;
    assign mem_addr     = in_access ? addr_q[31:2] : 30'd0;
    assign mem_data_in  = in_access ? lane_wdata : 32'd0;
    assign mem_write_en = in_access ? lane_mask : 4'b0000;

    assign lsu_done  = in_resp;
    assign lsu_adel  = in_resp && adel_q;
    assign lsu_ades  = in_resp && ades_q;
    assign lsu_dbe   = in_resp && dbe_q;
    assign lsu_rdata = (in_resp && !is_store(op_q) && !(adel_q || ades_q || dbe_q))
                       ? lane_rdata : 32'd0;
    assign dbg_state = state;

endmodule

// File: tb/tb_mips_lsu.sv
// Self-checking bench for mips_lsu: stores, loads, alignment faults, timeout,
// bus error, back-to-back issue and reset in the middle of an access.
module tb_mips_lsu;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst_b = 1'b0;
    logic        lsu_start = 1'b0;
    logic [2:0]  lsu_op = 3'd0;
    logic [31:0] lsu_addr = 32'd0;
    logic [31:0] lsu_wdata = 32'd0;
    logic [31:0] lsu_rdata;
    logic        lsu_stall, lsu_done, lsu_adel, lsu_ades, lsu_dbe;
    logic [29:0] mem_addr;
    logic [31:0] mem_data_in;
    logic [3:0]  mem_write_en;
    logic        mem_req;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_data_out = 32'd0;
    logic        mem_excpt = 1'b0;
    logic [1:0]  dbg_state;

    int n_cmp = 0;
    int n_err = 0;

    // Scoreboard entry: {adel, ades, dbe, rdata}
    logic [34:0] exp_q[$];
    int          exp_cyc_q[$];

    mips_lsu #(.TIMEOUT(TO)) dut (
        .clk          (clk),
        .rst_b        (rst_b),
        .lsu_start    (lsu_start),
        .lsu_op       (lsu_op),
        .lsu_addr     (lsu_addr),
        .lsu_wdata    (lsu_wdata),
        .lsu_rdata    (lsu_rdata),
        .lsu_stall    (lsu_stall),
        .lsu_done     (lsu_done),
        .lsu_adel     (lsu_adel),
        .lsu_ades     (lsu_ades),
        .lsu_dbe      (lsu_dbe),
        .mem_addr     (mem_addr),
        .mem_data_in  (mem_data_in),
        .mem_write_en (mem_write_en),
        .mem_req      (mem_req),
        .mem_ack      (mem_ack),
        .mem_data_out (mem_data_out),
        .mem_excpt    (mem_excpt),
        .dbg_state    (dbg_state)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] load_model(input logic [2:0] op, input logic [1:0] lo,
                                               input logic [31:0] word);
        logic [31:0] wb;
        logic [31:0] wh;
        wb = word >> (8 * lo);
        wh = word >> (16 * lo[1]);
        case (op)
            3'd0: return {{24{wb[7]}}, wb[7:0]};
            3'd1: return {{16{wh[15]}}, wh[15:0]};
            3'd2: return word;
            3'd3: return {24'd0, wb[7:0]};
            3'd4: return {16'd0, wh[15:0]};
            default: return 32'd0;
        endcase
    endfunction

    // Issues one instruction starting at the next cycle (cycle 0) and plays a
    // memory that acks in ACCESS cycle number `waits` (-1 = never).
    task automatic drive_access(input logic [2:0] op, input logic [31:0] addr,
                                input logic [31:0] wdata, input int waits,
                                input logic excpt, input logic [31:0] word,
                                output int cyc, output logic [34:0] res,
                                output logic saw_req, output logic [29:0] a,
                                output logic [31:0] d, output logic [3:0] m,
                                output logic stall_ok, output logic hold_ok);
        int acc;
        @(posedge clk); #1;
        lsu_start = 1'b1;
        lsu_op    = op;
        lsu_addr  = addr;
        lsu_wdata = wdata;
        #1;
        stall_ok = (lsu_stall === 1'b1);
        hold_ok  = 1'b1;
        saw_req  = 1'b0;
        cyc = -1; acc = 0; res = '0; a = '0; d = '0; m = '0;
        for (int c = 1; c <= 300; c++) begin
            @(posedge clk); #1;
            if (mem_req !== 1'b1 && mem_write_en !== 4'b0000) hold_ok = 1'b0;
            if (lsu_done === 1'b1) begin
                cyc = c;
                res = {lsu_adel, lsu_ades, lsu_dbe, lsu_rdata};
                if (lsu_stall !== 1'b0) stall_ok = 1'b0;
                lsu_start = 1'b0;
                mem_ack   = 1'b0;
                mem_excpt = 1'b0;
                break;
            end
            if (lsu_stall !== 1'b1) stall_ok = 1'b0;
            if (mem_req === 1'b1) begin
                if (!saw_req) begin
                    a = mem_addr; d = mem_data_in; m = mem_write_en;
                    saw_req = 1'b1;
                end else if (mem_addr !== a || mem_data_in !== d || mem_write_en !== m) begin
                    hold_ok = 1'b0;
                end
                if (acc == waits) begin
                    mem_ack = 1'b1; mem_excpt = excpt; mem_data_out = word;
                end else begin
                    mem_ack = 1'b0; mem_excpt = 1'b0; mem_data_out = $urandom;
                end
                acc++;
            end else begin
                mem_ack = 1'b0;
            end
        end
        if (cyc < 0) begin
            lsu_start = 1'b0;
            mem_ack   = 1'b0;
        end
    endtask

    task automatic test_reset;
        rst_b = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if ({lsu_rdata, lsu_stall, lsu_done, lsu_adel, lsu_ades, lsu_dbe, mem_addr,
             mem_data_in, mem_write_en, mem_req} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: got rdata=%h stall=%b done=%b req=%b we=%b addr=%h din=%h, want all 0",
                     lsu_rdata, lsu_stall, lsu_done, mem_req, mem_write_en, mem_addr, mem_data_in);
        end
        n_cmp++;
        if (dbg_state !== 2'd0) begin
            n_err++;
            $display("FAIL reset_state: got %0d want 0", dbg_state);
        end
        rst_b = 1'b1;
    endtask

    task automatic test_stores;
        logic [2:0]  t_op[3]   = '{3'd7, 3'd5, 3'd6};
        logic [31:0] t_addr[3] = '{32'h1000_0004, 32'h1000_0003, 32'h1000_0002};
        logic [31:0] t_wd[3]   = '{32'hDEAD_BEEF, 32'h0000_00A5, 32'h0000_1234};
        logic [31:0] t_din[3]  = '{32'hDEAD_BEEF, 32'hA5A5_A5A5, 32'h1234_1234};
        logic [3:0]  t_msk[3]  = '{4'b1111, 4'b1000, 4'b1100};
        int cyc; logic [34:0] res; logic sr, st_ok, h_ok;
        logic [29:0] a; logic [31:0] d; logic [3:0] m;
        logic [34:0] e; int ec;
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(35'd0);
            exp_cyc_q.push_back(2);
            drive_access(t_op[i], t_addr[i], t_wd[i], 0, 1'b0, 32'h0, cyc, res, sr, a, d, m, st_ok, h_ok);
            e = exp_q.pop_front(); ec = exp_cyc_q.pop_front();
            n_cmp++; if (res !== e) begin n_err++; $display("FAIL store%0d_result: got %h want %h", i, res, e); end
            n_cmp++; if (cyc != ec) begin n_err++; $display("FAIL store%0d_latency: got %0d want %0d", i, cyc, ec); end
            n_cmp++; if (a !== t_addr[i][31:2]) begin n_err++; $display("FAIL store%0d_addr: got %h want %h", i, a, t_addr[i][31:2]); end
            n_cmp++; if (d !== t_din[i]) begin n_err++; $display("FAIL store%0d_data: got %h want %h", i, d, t_din[i]); end
            n_cmp++; if (m !== t_msk[i]) begin n_err++; $display("FAIL store%0d_mask: got %b want %b", i, m, t_msk[i]); end
            n_cmp++; if (!st_ok || !h_ok) begin n_err++; $display("FAIL store%0d_stall_hold: got stall_ok=%b hold_ok=%b want 1/1", i, st_ok, h_ok); end
        end
    endtask

    task automatic test_loads;
        logic [2:0]  t_op[5]   = '{3'd0, 3'd3, 3'd1, 3'd4, 3'd2};
        logic [31:0] t_addr[5] = '{32'h1000_0003, 32'h1000_0003, 32'h1000_0000, 32'h1000_0002, 32'h1000_0000};
        logic [31:0] t_exp[5]  = '{32'hFFFF_FF80, 32'h0000_0080, 32'h0000_7F01, 32'h0000_80FF, 32'h80FF_7F01};
        int cyc; logic [34:0] res; logic sr, st_ok, h_ok;
        logic [29:0] a; logic [31:0] d; logic [3:0] m;
        logic [34:0] e; int ec;
        for (int i = 0; i < 5; i++) begin
            exp_q.push_back({3'b000, t_exp[i]});
            exp_cyc_q.push_back(5);
            drive_access(t_op[i], t_addr[i], 32'h5555_AAAA, 3, 1'b0, 32'h80FF_7F01, cyc, res, sr, a, d, m, st_ok, h_ok);
            e = exp_q.pop_front(); ec = exp_cyc_q.pop_front();
            n_cmp++; if (res !== e) begin n_err++; $display("FAIL load%0d_result: got %h want %h", i, res, e); end
            n_cmp++; if (cyc != ec) begin n_err++; $display("FAIL load%0d_latency: got %0d want %0d", i, cyc, ec); end
            n_cmp++; if (m !== 4'b0000 || !st_ok || !h_ok) begin n_err++; $display("FAIL load%0d_mask_stall: got mask=%b stall_ok=%b hold_ok=%b want 0000/1/1", i, m, st_ok, h_ok); end
        end
    endtask

    task automatic test_random_loads;
        logic [2:0] ops[5] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4};
        int cyc; logic [34:0] res; logic sr, st_ok, h_ok;
        logic [29:0] a; logic [31:0] d; logic [3:0] m;
        logic [34:0] e; int ec;
        logic [2:0] op; logic [1:0] lo; logic [31:0] word; int w;
        for (int i = 0; i < 8; i++) begin
            op   = ops[$urandom_range(0, 4)];
            lo   = 2'($urandom_range(0, 3));
            if (op == 3'd2) lo = 2'd0;
            if (op == 3'd1 || op == 3'd4) lo[0] = 1'b0;
            word = $urandom;
            w    = $urandom_range(0, 3);
            exp_q.push_back({3'b000, load_model(op, lo, word)});
            exp_cyc_q.push_back(2 + w);
            drive_access(op, {28'h0000_040, 2'b00, lo}, $urandom, w, 1'b0, word, cyc, res, sr, a, d, m, st_ok, h_ok);
            e = exp_q.pop_front(); ec = exp_cyc_q.pop_front();
            n_cmp++; if (res !== e || cyc != ec) begin n_err++; $display("FAIL rand_load%0d: got res=%h cyc=%0d want res=%h cyc=%0d (op=%0d lo=%0d)", i, res, cyc, e, ec, op, lo); end
        end
    endtask

    task automatic test_misaligned;
        logic [2:0]  t_op[4]   = '{3'd2, 3'd6, 3'd4, 3'd7};
        logic [31:0] t_addr[4] = '{32'h1000_0002, 32'h1000_0001, 32'h1000_0003, 32'h1000_0001};
        logic [34:0] t_exp[4]  = '{{3'b100, 32'd0}, {3'b010, 32'd0}, {3'b100, 32'd0}, {3'b010, 32'd0}};
        int cyc; logic [34:0] res; logic sr, st_ok, h_ok;
        logic [29:0] a; logic [31:0] d; logic [3:0] m;
        logic [34:0] e; int ec;
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(t_exp[i]);
            exp_cyc_q.push_back(1);
            drive_access(t_op[i], t_addr[i], 32'hFFFF_FFFF, 0, 1'b0, 32'hFFFF_FFFF, cyc, res, sr, a, d, m, st_ok, h_ok);
            e = exp_q.pop_front(); ec = exp_cyc_q.pop_front();
            n_cmp++; if (res !== e) begin n_err++; $display("FAIL misalign%0d_result: got %h want %h", i, res, e); end
            n_cmp++; if (cyc != ec) begin n_err++; $display("FAIL misalign%0d_latency: got %0d want %0d", i, cyc, ec); end
            n_cmp++; if (sr !== 1'b0) begin n_err++; $display("FAIL misalign%0d_no_req: got req_seen=%b want 0", i, sr); end
        end
    endtask

    task automatic test_timeout;
        int cyc; logic [34:0] res; logic sr, st_ok, h_ok;
        logic [29:0] a; logic [31:0] d; logic [3:0] m;
        logic [34:0] e; int ec;
        exp_q.push_back({3'b001, 32'd0});
        exp_cyc_q.push_back(TO + 2);
        drive_access(3'd2, 32'h1000_0100, 32'h0, -1, 1'b0, 32'h0, cyc, res, sr, a, d, m, st_ok, h_ok);
        e = exp_q.pop_front(); ec = exp_cyc_q.pop_front();
        n_cmp++; if (res !== e) begin n_err++; $display("FAIL timeout_result: got %h want %h", res, e); end
        n_cmp++; if (cyc != ec) begin n_err++; $display("FAIL timeout_latency: got %0d want %0d", cyc, ec); end
    endtask

    task automatic test_bus_error;
        int cyc; logic [34:0] res; logic sr, st_ok, h_ok;
        logic [29:0] a; logic [31:0] d; logic [3:0] m;
        logic [34:0] e; int ec;
        exp_q.push_back({3'b001, 32'd0});
        exp_cyc_q.push_back(3);
        drive_access(3'd2, 32'h1000_0200, 32'h0, 1, 1'b1, 32'h1234_5678, cyc, res, sr, a, d, m, st_ok, h_ok);
        e = exp_q.pop_front(); ec = exp_cyc_q.pop_front();
        n_cmp++; if (res !== e) begin n_err++; $display("FAIL bus_error_result: got %h want %h", res, e); end
        n_cmp++; if (cyc != ec) begin n_err++; $display("FAIL bus_error_latency: got %0d want %0d", cyc, ec); end
    endtask

    task automatic test_back_to_back;
        int cyc; logic [34:0] res; logic sr, st_ok, h_ok;
        logic [29:0] a; logic [31:0] d; logic [3:0] m;
        logic [34:0] e; int ec;
        exp_q.push_back({3'b000, 32'hCAFE_F00D});
        exp_cyc_q.push_back(2);
        drive_access(3'd2, 32'h1000_0300, 32'h0, 0, 1'b0, 32'hCAFE_F00D, cyc, res, sr, a, d, m, st_ok, h_ok);
        e = exp_q.pop_front(); ec = exp_cyc_q.pop_front();
        n_cmp++; if (res !== e || cyc != ec) begin n_err++; $display("FAIL b2b_first: got res=%h cyc=%0d want res=%h cyc=%0d", res, cyc, e, ec); end
        exp_q.push_back(35'd0);
        exp_cyc_q.push_back(2);
        drive_access(3'd5, 32'h1000_0301, 32'h0000_003C, 0, 1'b0, 32'h0, cyc, res, sr, a, d, m, st_ok, h_ok);
        e = exp_q.pop_front(); ec = exp_cyc_q.pop_front();
        n_cmp++; if (res !== e || cyc != ec) begin n_err++; $display("FAIL b2b_second: got res=%h cyc=%0d want res=%h cyc=%0d", res, cyc, e, ec); end
        n_cmp++; if (m !== 4'b0010 || d !== 32'h3C3C_3C3C) begin n_err++; $display("FAIL b2b_second_lanes: got mask=%b data=%h want 0010/3c3c3c3c", m, d); end
    endtask

    task automatic test_reset_mid_access;
        int cyc; logic [34:0] res; logic sr, st_ok, h_ok;
        logic [29:0] a; logic [31:0] d; logic [3:0] m;
        logic [34:0] e; int ec;
        @(posedge clk); #1;
        lsu_start = 1'b1; lsu_op = 3'd7; lsu_addr = 32'h1000_0400; lsu_wdata = 32'h0BAD_0BAD;
        mem_ack = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        n_cmp++; if (mem_req !== 1'b1) begin n_err++; $display("FAIL rst_mid_req_before: got %b want 1", mem_req); end
        rst_b = 1'b0; lsu_start = 1'b0;
        @(posedge clk); #1;
        rst_b = 1'b1;
        n_cmp++; if (mem_req !== 1'b0 || mem_write_en !== 4'b0000) begin n_err++; $display("FAIL rst_mid_req_after: got req=%b we=%b want 0/0000", mem_req, mem_write_en); end
        n_cmp++; if (dbg_state !== 2'd0) begin n_err++; $display("FAIL rst_mid_state: got %0d want 0", dbg_state); end
        n_cmp++; if (lsu_done !== 1'b0 || lsu_stall !== 1'b0) begin n_err++; $display("FAIL rst_mid_done: got done=%b stall=%b want 0/0", lsu_done, lsu_stall); end
        exp_q.push_back({3'b000, 32'h0123_4567});
        exp_cyc_q.push_back(3);
        drive_access(3'd2, 32'h1000_0404, 32'h0, 1, 1'b0, 32'h0123_4567, cyc, res, sr, a, d, m, st_ok, h_ok);
        e = exp_q.pop_front(); ec = exp_cyc_q.pop_front();
        n_cmp++; if (res !== e || cyc != ec) begin n_err++; $display("FAIL rst_mid_followup: got res=%h cyc=%0d want res=%h cyc=%0d", res, cyc, e, ec); end
    endtask

    initial begin
        test_reset();
        test_stores();
        test_loads();
        test_random_loads();
        test_misaligned();
        test_timeout();
        test_bus_error();
        test_back_to_back();
        test_reset_mid_access();
        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
